// File: rtl/readout_pkg.sv
// Shared widths, FSM state encoding and word packing for the readout scheduler.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package readout_pkg;

    localparam int DEF_ID_W   = 2;
    localparam int DEF_SEQ_W  = 6;
    localparam int DEF_DATA_W = 24;
    localparam int WORD_W     = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [DEF_ID_W-1:0]   id,
        input logic [DEF_SEQ_W-1:0]  seq,
        input logic [DEF_DATA_W-1:0] data
    );
        return {id, seq, data};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starts after the last winner.
// Latency: grant is combinational; pointer moves on the edge where advance_i is high.
// Backpressure: pointer holds until the consumer advances it.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] next_ptr;
    logic             found;

    // Two passes: requesters at or above the pointer first, then wrap to the low ones.
    always_comb begin
        grant_o  = '0;
        next_ptr = ptr_q;
        found    = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (j >= int'(ptr_q))) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                next_ptr   = PTR_W'((j == N-1) ? 0 : j + 1);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                next_ptr   = PTR_W'((j == N-1) ? 0 : j + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= next_ptr;
        end
    end

endmodule

// File: rtl/readout_scheduler.sv
// Shares one tagged output register pair between NUM_SRC producers via per-source slots; `READOUT_TIMESTAMP_EN adds capture timestamps.
// Latency: tick at n -> slot at n+1 -> valid_o at n+2 when idle; back-to-back on ack.
// Backpressure: output held until ack_i; a full slot is overwritten by newer data and counted as a drop.
module readout_scheduler #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = readout_pkg::DEF_DATA_W,
    parameter int SEQ_W   = readout_pkg::DEF_SEQ_W,
    parameter int ID_W    = readout_pkg::DEF_ID_W,
    parameter int DROP_W  = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic [NUM_SRC-1:0]              tick_i,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]  a_i,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]  b_i,
    output logic [31:0]                     oreg1_o,
    output logic [31:0]                     oreg2_o,
    output logic                            valid_o,
    input  logic                            ack_i,
    output logic [NUM_SRC-1:0][DROP_W-1:0]  drop_cnt_o,
    output logic [31:0]                     ts_o
);
    import readout_pkg::*;

    generate
        if (ID_W + SEQ_W + DATA_W != 32) begin : g_bad_word_width
            $error("readout_scheduler: ID_W+SEQ_W+DATA_W must equal 32");
        end
        // pack_word is sized by the package defaults.
        if (ID_W != DEF_ID_W || SEQ_W != DEF_SEQ_W || DATA_W != DEF_DATA_W) begin : g_bad_field_width
            $error("readout_scheduler: field widths must match readout_pkg defaults");
        end
        if (NUM_SRC < 2 || NUM_SRC > 4) begin : g_bad_num_src
            $error("readout_scheduler: NUM_SRC must be 2..4");
        end
    endgenerate

    logic [NUM_SRC-1:0][DATA_W-1:0] slot_a, slot_b;
    logic [NUM_SRC-1:0][SEQ_W-1:0]  slot_seq, seq_cnt;
    logic [NUM_SRC-1:0][DROP_W-1:0] drop_cnt;
    logic [NUM_SRC-1:0]             pending, grant;
    logic [ID_W-1:0]                sel_id;
    logic [SEQ_W-1:0]               sel_seq;
    logic [DATA_W-1:0]              sel_a, sel_b;
    logic [31:0]                    oreg1_q, oreg2_q;
    logic                           load;
    state_t                         state_q, state_d;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .req_i     (pending),
        .advance_i (load),
        .grant_o   (grant)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (|pending) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (ack_i) begin
                    if (|pending) load    = 1'b1;
                    else          state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= ST_EMPTY;
        else           state_q <= state_d;
    end

    // A grant reads the slot's old contents, so a same-cycle tick is not a drop.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            slot_a   <= '0;
            slot_b   <= '0;
            slot_seq <= '0;
            seq_cnt  <= '0;
            drop_cnt <= '0;
            pending  <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (tick_i[k]) begin
                    slot_a[k]   <= a_i[k];
                    slot_b[k]   <= b_i[k];
                    slot_seq[k] <= seq_cnt[k];
                    seq_cnt[k]  <= seq_cnt[k] + SEQ_W'(1);
                    if (pending[k] && !(load && grant[k]) && (drop_cnt[k] != '1))
                        drop_cnt[k] <= drop_cnt[k] + DROP_W'(1);
                end
                pending[k] <= tick_i[k] | (pending[k] & ~(load & grant[k]));
            end
        end
    end

    always_comb begin
        sel_id  = '0;
        sel_seq = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant[k]) begin
                sel_id  = ID_W'(k);
                sel_seq = slot_seq[k];
                sel_a   = slot_a[k];
                sel_b   = slot_b[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            oreg1_q <= '0;
            oreg2_q <= '0;
        end else if (load) begin
            oreg1_q <= pack_word(sel_id, sel_seq, sel_a);
            oreg2_q <= pack_word(sel_id, sel_seq, sel_b);
        end
    end

`ifdef READOUT_TIMESTAMP_EN
    logic [31:0]               ts_cnt, ts_q, sel_ts;
    logic [NUM_SRC-1:0][31:0]  slot_ts;

    always_comb begin
        sel_ts = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant[k]) sel_ts = slot_ts[k];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ts_cnt  <= '0;
            ts_q    <= '0;
            slot_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (tick_i[k]) slot_ts[k] <= ts_cnt;
            end
            if (load) ts_q <= sel_ts;
        end
    end

    assign ts_o = ts_q;
`else
    assign ts_o = '0;
`endif

    assign oreg1_o    = oreg1_q;
    assign oreg2_o    = oreg2_q;
    assign valid_o    = (state_q == ST_FULL);
    assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_readout_scheduler.sv
// Directed bench for readout_scheduler with hand-computed expected words and counters.
module tb_readout_scheduler;

    logic             clk = 1'b0;
    logic             reset_ni;
    logic [2:0]       tick;
    logic [2:0][23:0] a, b;
    logic             ack;
    logic [31:0]      oreg1, oreg2, ts;
    logic             valid;
    logic [2:0][7:0]  drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    readout_scheduler #(
        .NUM_SRC(3), .DATA_W(24), .SEQ_W(6), .ID_W(2), .DROP_W(8)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .tick_i     (tick),
        .a_i        (a),
        .b_i        (b),
        .oreg1_o    (oreg1),
        .oreg2_o    (oreg2),
        .valid_o    (valid),
        .ack_i      (ack),
        .drop_cnt_o (drop),
        .ts_o       (ts)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_one(input int k, input logic [23:0] av, input logic [23:0] bv);
        tick    = '0;
        tick[k] = 1'b1;
        a[k]    = av;
        b[k]    = bv;
        cyc();
        tick    = '0;
    endtask

    task automatic tick_rep(input int k, input int n, input logic [23:0] av);
        tick    = '0;
        tick[k] = 1'b1;
        a[k]    = av;
        b[k]    = av;
        cyc(n);
        tick    = '0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    function automatic logic [31:0] w(input int id, input int seq, input logic [23:0] d);
        return {id[1:0], seq[5:0], d};
    endfunction

    logic [31:0] t0, t1;

    initial begin
        reset_ni = 1'b0;
        tick = '0; a = '0; b = '0; ack = 1'b0;
        cyc(3);
        reset_ni = 1'b1;
        cyc();
        chk("rst_valid", valid, 0);
        chk("rst_oreg1", oreg1, 0);
        chk("rst_oreg2", oreg2, 0);
        chk("rst_drop", drop, 0);
        chk("rst_ts", ts, 0);

        // Build up state, then reset mid-stream.
        tick_one(0, 24'h000AAA, 24'h000BBB);
        cyc();
        chk("pre_valid", valid, 1);
        tick_one(2, 24'h1, 24'h1);
        tick_one(2, 24'h2, 24'h2);
        chk("pre_drop2", drop[2], 1);
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_oreg1", oreg1, 0);
        chk("mid_rst_oreg2", oreg2, 0);
        chk("mid_rst_drop", drop, 0);
        chk("mid_rst_ts", ts, 0);
        #2;
        reset_ni = 1'b1;
        cyc();
        chk("post_rst_no_word", valid, 0);

        // First-transaction latency.
        tick_one(0, 24'h000123, 24'h000456);
        chk("lat_n1_valid", valid, 0);
        cyc();
        chk("lat_n2_valid", valid, 1);
        chk("lat_oreg1", oreg1, 32'h00000123);
        chk("lat_oreg2", oreg2, 32'h00000456);
        ack_pulse();
        chk("ack_to_empty", valid, 0);
        ack_pulse();
        chk("ack_empty_ignored_valid", valid, 0);
        chk("ack_empty_hold_oreg1", oreg1, 32'h00000123);

        // Tick coinciding with grant: no drop, second word follows on ack.
        tick_one(1, 24'h7FFFFF, 24'h800000);
        tick_one(1, 24'h7FFFFF, 24'h800000);
        chk("hold_w1_oreg1", oreg1, w(1, 0, 24'h7FFFFF));
        chk("hold_drop1", drop[1], 0);
        ack_pulse();
        chk("b2b_valid", valid, 1);
        chk("b2b_oreg1", oreg1, w(1, 1, 24'h7FFFFF));
        chk("b2b_oreg2", oreg2, 32'h41800000);
        ack_pulse();
        chk("b2b_empty", valid, 0);

        // Overwrite while output held by src0.
        tick_one(0, 24'h10, 24'h11);
        cyc();
        chk("ovw_src0_word", oreg1, w(0, 1, 24'h10));
        tick_one(2, 24'h21, 24'h31);
        tick_one(2, 24'h22, 24'h32);
        tick_one(2, 24'h23, 24'h33);
        chk("ovw_drop2", drop[2], 2);
        ack_pulse();
        chk("ovw_oreg1", oreg1, w(2, 2, 24'h23));
        chk("ovw_oreg2", oreg2, w(2, 2, 24'h33));
        ack_pulse();
        chk("ovw_empty", valid, 0);

        // Round-robin with all pending and ack every cycle.
        tick = 3'b111;
        for (int k = 0; k < 3; k++) begin
            a[k] = 24'h100 + 24'(k);
            b[k] = 24'h200 + 24'(k);
        end
        cyc();
        tick = '0;
        cyc();
        chk("rr_w0", oreg1, w(0, 2, 24'h100));
        ack = 1'b1;
        cyc();
        chk("rr_w1", oreg1, w(1, 2, 24'h101));
        chk("rr_v1", valid, 1);
        cyc();
        chk("rr_w2", oreg1, w(2, 3, 24'h102));
        chk("rr_v2", valid, 1);
        ack = 1'b0;
        cyc();
        chk("rr_hold_w2", oreg2, w(2, 3, 24'h202));
        ack_pulse();
        chk("rr_empty", valid, 0);

        // Seq wrap and drop saturation on src0 while src1 holds the output.
        tick_one(1, 24'h200, 24'h201);
        cyc();
        chk("sat_hold_src1", oreg1, w(1, 3, 24'h200));
        tick_rep(0, 62, 24'h3D);
        chk("sat_drop61", drop[0], 61);
        ack_pulse();
        chk("wrap_seq0", oreg1, w(0, 0, 24'h3D));
        tick_rep(0, 194, 24'hABC);
        chk("sat_drop254", drop[0], 254);
        tick_rep(0, 1, 24'hABC);
        chk("sat_drop255", drop[0], 255);
        tick_rep(0, 106, 24'hABC);
        chk("sat_drop_stays", drop[0], 255);
        chk("sat_drop1_zero", drop[1], 0);
        ack_pulse();
        chk("sat_seq45", oreg1, w(0, 45, 24'hABC));
        ack_pulse();
        chk("sat_empty", valid, 0);

`ifdef READOUT_TIMESTAMP_EN
        tick_one(1, 24'h1, 24'h1);
        cyc(9);
        tick_one(1, 24'h2, 24'h2);
        t0 = ts;
        ack_pulse();
        t1 = ts;
        chk("ts_delta", t1 - t0, 10);
        ack_pulse();
`else
        tick_one(1, 24'h1, 24'h1);
        cyc();
        t0 = ts;
        t1 = 32'd0;
        chk("ts_valid", valid, 1);
        chk("ts_tied_zero", t0, t1);
        ack_pulse();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
